// File: rtl/fc_act_loader.sv
// fc_act_loader: assembles IN streamed activations into the parallel x vector feeding fc1.
// Define FC_ACT_LOADER_DBUF_EN for ping-pong banks; default build is a single FILL/HOLD bank.
module fc_act_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  output logic [0:IN-1][WIDTH-1:0] x,
  output logic                     x_valid,
  input  logic                     x_ready,
  output logic                     err_len
);
  localparam int            IW   = $clog2(IN);
  localparam logic [IW-1:0] LAST = IW'(IN - 1);

  logic [IW-1:0] idx;
  logic          acc, done, rel;

  assign acc  = s_valid && s_ready;
  assign done = acc && (idx == LAST);
  assign rel  = x_valid && x_ready;

  // An early s_last drops the partial frame; a missing one still completes at IN beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= acc && (s_last != (idx == LAST));
      if (acc) idx <= (done || s_last) ? '0 : idx + IW'(1);
    end
  end

`ifdef FC_ACT_LOADER_DBUF_EN
  logic [1:0][0:IN-1][WIDTH-1:0] bank;
  logic                          wsel, rsel;
  logic [1:0]                    fcnt, fcnt_nx;

  // Completion and release in the same cycle cancel out in the full-bank count.
  always_comb begin
    fcnt_nx = fcnt;
    if (done && !rel)      fcnt_nx = fcnt + 2'd1;
    else if (rel && !done) fcnt_nx = fcnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank    <= '0;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      fcnt    <= 2'd0;
      s_ready <= 1'b0;
      x_valid <= 1'b0;
    end else begin
      if (acc)  bank[wsel][idx] <= s_data;
      if (done) wsel <= ~wsel;
      if (rel)  rsel <= ~rsel;
      fcnt    <= fcnt_nx;
      x_valid <= (fcnt_nx != 2'd0);
      s_ready <= (fcnt_nx < 2'd2);
    end
  end

  assign x = bank[rsel];
`else
  typedef enum logic {FILL, HOLD} state_t;
  state_t                   state;
  logic [0:IN-1][WIDTH-1:0] bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      bank    <= '0;
      s_ready <= 1'b0;
      x_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (acc) bank[idx] <= s_data;
          if (done) begin
            state   <= HOLD;
            s_ready <= 1'b0;
            x_valid <= 1'b1;
          end
        end
        HOLD: if (rel) begin
          state   <= FILL;
          s_ready <= 1'b1;
          x_valid <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end

  assign x = bank;
`endif
endmodule

// File: tb/tb_fc_act_loader.sv
// Directed bench for fc_act_loader: frames streamed by tasks, delivered frames checked against a scoreboard.
module tb_fc_act_loader;
  localparam int IN = 400;
  localparam int W  = 8;
`ifdef FC_ACT_LOADER_DBUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  typedef logic [0:IN-1][W-1:0] vec_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] s_data = '0;
  logic       s_valid = 1'b0, s_last = 1'b0, x_ready = 1'b0;
  logic       s_ready, x_valid, err_len;
  vec_t       x;

  vec_t sbq[$];
  int   nchk = 0, nerr = 0, npop = 0, nexp = 0, stalls = 0;
  logic pre_valid;
  vec_t eb, zv;

  fc_act_loader #(.WIDTH(W), .IN(IN)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .x(x), .x_valid(x_valid), .x_ready(x_ready), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chkv(input string tag, input vec_t got, input vec_t exp);
    int bad = 0;
    for (int i = IN - 1; i >= 0; i--) if (got[i] !== exp[i]) bad = i;
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s x[%0d] got=%0h exp=%0h", tag, bad, got[bad], exp[bad]);
    end
  endtask

  function automatic vec_t mkvec(input int mul, input int add);
    vec_t v;
    for (int i = 0; i < IN; i++) v[i] = 8'((i * mul + add) % 256);
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 1000) begin @(negedge clk); n++; stalls++; end
    if (!s_ready) begin
      nerr++;
      $display("FAIL s_ready_timeout got=0 exp=1");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $fatal(1, "stream stalled");
    end
  endtask

  // Called and returns at a falling edge; a full-length frame is pushed to the scoreboard.
  task automatic send_frame(input int n, input int mul, input int add, input logic lastbit,
                            input logic rdy_on_last);
    vec_t e = mkvec(mul, add);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 8'((i * mul + add) % 256);
      s_last  = (i == n - 1) ? lastbit : 1'b0;
      if (i == n - 1) begin
        pre_valid = x_valid;
        if (rdy_on_last) x_ready = 1'b1;
        if (n == IN) begin sbq.push_back(e); nexp++; end
      end
      wait_ready();
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (x_valid && n < 20) begin @(negedge clk); n++; end
    chk("drain", x_valid, 0);
  endtask

  // Scoreboard: every output handshake must deliver the oldest expected frame.
  always @(negedge clk) begin
    #1;
    if (rst_n && x_valid && x_ready) begin
      if (sbq.size() == 0) chk("sb_unexpected", sbq.size(), 1);
      else begin
        chkv("sb_frame", x, sbq.pop_front());
        npop++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zv = '0;
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_err_len", err_len, 0);
    chkv("rst_x", x, zv);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);

    // nominal frame i%256
    x_ready = 1'b1;
    send_frame(IN, 1, 0, 1'b1, 1'b0);
    chk("nom_pre_valid", pre_valid, 0);
    chk("nom_valid", x_valid, 1);
    chk("nom_err", err_len, 0);
    chk("nom_x0", x[0], 0);
    chk("nom_x255", x[255], 255);
    chk("nom_x399", x[399], 143);
    @(negedge clk);

    // backpressure: output held 50 cycles
    x_ready = 1'b0;
    eb = mkvec(7, 3);
    send_frame(IN, 7, 3, 1'b1, 1'b0);
    if (DB) send_frame(IN, 5, 1, 1'b1, 1'b0);
    for (int c = 0; c < 50; c++) begin
      chk("bp_valid", x_valid, 1);
      chkv("bp_x", x, eb);
      chk("bp_s_ready", s_ready, 0);
      @(negedge clk);
    end
    x_ready = 1'b1;
    drain();

    // early s_last on beat 99
    send_frame(100, 1, 0, 1'b1, 1'b0);
    chk("early_err", err_len, 1);
    chk("early_novalid", x_valid, 0);
    @(negedge clk);
    chk("early_err_off", err_len, 0);
    chk("early_novalid2", x_valid, 0);
    send_frame(IN, 1, 50, 1'b1, 1'b0);
    chk("after_early_x0", x[0], 50);
    chk("after_early_valid", x_valid, 1);
    chk("after_early_err", err_len, 0);
    @(negedge clk);

    // missing s_last on beat 399
    send_frame(IN, 2, 9, 1'b0, 1'b0);
    chk("miss_err", err_len, 1);
    chk("miss_valid", x_valid, 1);
    @(negedge clk);
    chk("miss_err_off", err_len, 0);
    drain();

    // reset at beat 137
    send_frame(137, 1, 0, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'd137;
    rst_n   = 1'b0;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_x_valid", x_valid, 0);
    chk("midrst_err", err_len, 0);
    chkv("midrst_x", x, zv);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("midrst_ready_up", s_ready, 1);
    send_frame(IN, 3, 11, 1'b1, 1'b0);
    chk("midrst_x0", x[0], 11);
    chk("midrst_valid", x_valid, 1);
    drain();

    // back-to-back constant frames; double-buffer build also forces completion+release together
    stalls = 0;
    if (DB) x_ready = 1'b0;
    send_frame(IN, 0, 0, 1'b1, 1'b0);
    chk("b2b0_x0", x[0], 0);
    chk("b2b0_valid", x_valid, 1);
    send_frame(IN, 0, 1, 1'b1, DB);
    chk("b2b1_x0", x[0], 1);
    chk("b2b1_valid", x_valid, 1);
    send_frame(IN, 0, 2, 1'b1, 1'b0);
    chk("b2b2_x0", x[0], 2);
    if (DB) chk("b2b_stalls", stalls, 0);
    x_ready = 1'b1;
    drain();

    chk("sb_empty", sbq.size(), 0);
    chk("frames_delivered", npop, nexp);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
